l2_line_responder: RTL and testbench

- Behavioural L2 memory-side responder for the L1D cache controller's L2 interface.
- Serves line-fill requests (read_l2) by streaming one 32-byte line after a fixed access latency, critical word first, with l2_ack on the final beat.
- Absorbs write-back / write-through bursts (write_l2) into a local word array.
- Used as the L2 model in controller-level simulation and as the basis for the synthesizable L2 front end.

---
 rtl/l2_line_responder_if.sv | 39 +++
 rtl/l2_line_responder.sv | 169 ++++++++++++++++
 tb/tb_l2_line_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/l2_line_responder_if.sv
// Request/response bundle between the L1D controller (master) and the L2 line responder (slave).
interface l2_line_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              read_l2;
  logic              write_l2;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              l2_ack;
  logic              busy;
  logic              burst_err;

  modport master (
    output read_l2,
    output write_l2,
    output addr,
    output wdata,
    input  rdata,
    input  rdata_valid,
    input  l2_ack,
    input  busy,
    input  burst_err
  );

  modport slave (
    input  read_l2,
    input  write_l2,
    input  addr,
    input  wdata,
    output rdata,
    output rdata_valid,
    output l2_ack,
    output busy,
    output burst_err
  );
endinterface

// File: rtl/l2_line_responder.sv
// L2 memory-side responder: critical-word-first line fills after a fixed latency,
// and write bursts absorbed into a local word array.
module l2_line_responder #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LINE_WORDS   = 8,
  parameter int READ_LATENCY = 4,
  parameter int MEM_WORDS    = 1024
) (
  input  logic               clk,
  input  logic               reset,
  l2_line_responder_if.slave bus
);
  localparam int LW_BITS = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int LINE_W  = IDX_W - LW_BITS;

  localparam logic [3:0] LAST_BEAT = 4'(LINE_WORDS - 1);
  localparam logic [3:0] LAT_LOAD  = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_BURST = 2'd3
  } state_t;

  state_t              state_q;
  logic [LINE_W-1:0]   line_q;
  logic [LW_BITS-1:0]  start_q;
  logic [3:0]          beat_q;
  logic [3:0]          lat_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rdata_valid_q;
  logic                ack_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem_q [MEM_WORDS];

  logic [LINE_W-1:0]   req_line;
  logic [LW_BITS-1:0]  req_start;
  logic [LW_BITS-1:0]  offset;
  logic [IDX_W-1:0]    word_addr;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic                rd_issue;
  logic                last_beat;
  logic                unused_addr_bits;

  assign req_line  = bus.addr[2+LW_BITS +: LINE_W];
  assign req_start = bus.addr[2 +: LW_BITS];

  // Word order wraps inside the line: the offset add is deliberately truncated.
  assign offset    = start_q + beat_q[LW_BITS-1:0];
  assign word_addr = {line_q, offset};
  assign last_beat = (beat_q == LAST_BEAT);
  assign rd_issue  = (state_q == RD_BURST) || ((state_q == RD_WAIT) && (lat_q == 4'd0));

  // Upper address bits alias; byte offset is ignored.
  assign unused_addr_bits = ^{bus.addr[1:0], bus.addr[ADDR_W-1:2+IDX_W]};

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {req_line, req_start};
    if (reset) begin
      if ((state_q == IDLE) && bus.write_l2) begin
        mem_we = 1'b1;
      end else if ((state_q == WR_BURST) && bus.write_l2) begin
        mem_we    = 1'b1;
        mem_waddr = word_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      line_q        <= '0;
      start_q       <= '0;
      beat_q        <= 4'd0;
      lat_q         <= 4'd0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;

      // Beat issue is shared by the last RD_WAIT cycle and RD_BURST so the
      // first beat lands exactly READ_LATENCY edges after acceptance.
      if (rd_issue) begin
        rdata_q       <= mem_q[word_addr];
        rdata_valid_q <= 1'b1;
        if (last_beat) begin
          ack_q   <= 1'b1;
          beat_q  <= 4'd0;
          state_q <= IDLE;
        end else begin
          beat_q  <= beat_q + 4'd1;
          state_q <= RD_BURST;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.write_l2) begin
            line_q  <= req_line;
            start_q <= req_start;
            if (LAST_BEAT == 4'd0) begin
              ack_q  <= 1'b1;
              beat_q <= 4'd0;
            end else begin
              beat_q  <= 4'd1;
              state_q <= WR_BURST;
            end
          end else if (bus.read_l2) begin
            line_q  <= req_line;
            start_q <= req_start;
            beat_q  <= 4'd0;
            lat_q   <= LAT_LOAD;
            state_q <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (lat_q != 4'd0) begin
            lat_q <= lat_q - 4'd1;
          end
        end

        RD_BURST: begin
        end

        WR_BURST: begin
          if (bus.write_l2) begin
            if (last_beat) begin
              ack_q   <= 1'b1;
              beat_q  <= 4'd0;
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end else begin
            err_q   <= 1'b1;
            beat_q  <= 4'd0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.l2_ack      = ack_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.burst_err   = err_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder: fills, critical word first, abort, collision, aliasing, reset.
module tb_l2_line_responder;
  localparam int LAT = 4;
  localparam int LW  = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  l2_line_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  l2_line_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .LINE_WORDS  (LW),
    .READ_LATENCY(LAT),
    .MEM_WORDS   (1024)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q [LW];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [31:0] v0, input int start);
    for (int i = 0; i < LW; i++) exp_q[i] = v0 + 32'((start + i) % LW);
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [31:0] v0, input int n, input bit with_read);
    bus.addr     = a;
    bus.write_l2 = 1'b1;
    bus.read_l2  = with_read;
    for (int i = 0; i < n; i++) begin
      bus.wdata = v0 + 32'(i);
      step();
      bus.read_l2 = 1'b0;
      check_eq("wr_ack", 32'(bus.l2_ack), 32'(i == LW - 1));
      check_eq("wr_err", 32'(bus.burst_err), 32'd0);
      check_eq("wr_no_valid", 32'(bus.rdata_valid), 32'd0);
    end
    bus.write_l2 = 1'b0;
    if (n < LW) begin
      step();
      check_eq("abort_err", 32'(bus.burst_err), 32'd1);
      check_eq("abort_no_ack", 32'(bus.l2_ack), 32'd0);
    end
    check_eq("wr_idle", 32'(bus.busy), 32'd0);
    $display("[TB] write addr=%h beats=%0d first=%h read_too=%0d", a, n, v0, with_read);
  endtask

  task automatic rd_line(input logic [31:0] a);
    bus.addr    = a;
    bus.read_l2 = 1'b1;
    step();
    bus.read_l2 = 1'b0;
    check_eq("rd_busy", 32'(bus.busy), 32'd1);
    check_eq("rd_wait_valid", 32'(bus.rdata_valid), 32'd0);
    for (int k = 1; k < LAT; k++) begin
      step();
      check_eq("rd_wait_valid", 32'(bus.rdata_valid), 32'd0);
    end
    for (int i = 0; i < LW; i++) begin
      step();
      check_eq("rd_valid", 32'(bus.rdata_valid), 32'd1);
      check_eq("rd_data", bus.rdata, exp_q[i]);
      check_eq("rd_ack", 32'(bus.l2_ack), 32'(i == LW - 1));
    end
    step();
    check_eq("rd_end_valid", 32'(bus.rdata_valid), 32'd0);
    check_eq("rd_end_busy", 32'(bus.busy), 32'd0);
    check_eq("rd_end_ack", 32'(bus.l2_ack), 32'd0);
    $display("[TB] read addr=%h first=%h last=%h", a, exp_q[0], exp_q[LW-1]);
  endtask

  initial begin
    reset        = 1'b0;
    bus.read_l2  = 1'b0;
    bus.write_l2 = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    #12;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_valid", 32'(bus.rdata_valid), 32'd0);
    check_eq("rst_ack", 32'(bus.l2_ack), 32'd0);
    check_eq("rst_err", 32'(bus.burst_err), 32'd0);
    check_eq("rst_rdata", bus.rdata, 32'd0);
    step();
    reset = 1'b1;
    step();

    // Full write then in-order read.
    wr_burst(32'h0000_0040, 32'hA0, LW, 1'b0);
    set_exp(32'hA0, 0);
    rd_line(32'h0000_0040);

    // Critical word first: word 6.
    set_exp(32'hA0, 6);
    rd_line(32'h0000_0058);

    // Prefill line 0x80, then abort a burst after three beats.
    wr_burst(32'h0000_0080, 32'hC0, LW, 1'b0);
    wr_burst(32'h0000_0080, 32'hB0, 3, 1'b0);
    exp_q = '{32'hB0, 32'hB1, 32'hB2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7};
    rd_line(32'h0000_0080);

    // Read and write in the same IDLE cycle: write wins.
    wr_burst(32'h0000_00C0, 32'hD0, LW, 1'b1);
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      check_eq("coll_no_valid", 32'(bus.rdata_valid), 32'd0);
    end
    set_exp(32'hD0, 0);
    rd_line(32'h0000_00C0);

    // Aliased address returns the same line.
    set_exp(32'hA0, 0);
    rd_line(32'h0000_1040);

    // Asynchronous reset at beat 3 of a read burst.
    bus.addr    = 32'h0000_0040;
    bus.read_l2 = 1'b1;
    step();
    bus.read_l2 = 1'b0;
    for (int k = 0; k < LAT + 3; k++) step();
    check_eq("pre_rst_data", bus.rdata, 32'hA3);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(bus.rdata_valid), 32'd0);
    check_eq("mid_rst_ack", 32'(bus.l2_ack), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    reset = 1'b1;
    for (int k = 0; k < LW + LAT; k++) begin
      step();
      check_eq("post_rst_busy", 32'(bus.busy), 32'd0);
      check_eq("post_rst_ack", 32'(bus.l2_ack), 32'd0);
    end
    $display("[TB] reset mid-burst done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
